// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
//
// Purpose:
//   Inter-stage pipeline register (IF/ID, ID/EX, EX/ME, ME/WB) with a
//   valid/ready handshake and a two-entry skid buffer. Because the skid entry
//   absorbs the one word already in flight, in_ready is a function of the
//   stored state only. There is no combinational path from out_ready back
//   upstream. An empty or flushed stage presents NOP_VALUE downstream.
//
// Parameters:
//   WIDTH      payload bits per entry
//   NOP_VALUE  bubble payload shown while out_valid=0; reset value of entries
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   upstream offers in_data
//   in_ready   stage can accept this cycle (0 while FULL or in reset)
//   in_data    upstream payload
//   out_valid  out_data holds a real instruction
//   out_ready  downstream accepts this cycle (0 = stall)
//   out_data   payload to next stage, NOP_VALUE when out_valid=0
//   flush      synchronous squash of held and incoming data
//
// Optional feature (macro PIPE_SKID_STATS_EN):
//   stall_cnt  [15:0] saturating count of cycles with out_valid & !out_ready
//   flush_cnt  [7:0]  saturating count of flush cycles while an entry was held
// -----------------------------------------------------------------------------
module pipe_skid_stage #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [15:0]      stall_cnt,
    output logic [7:0]       flush_cnt
`endif
);

    // EMPTY: no entry valid; ONE: main only; FULL: main + skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           stateReg;
    state_t           stateNext;
    logic [WIDTH-1:0] mainDataReg;
    logic [WIDTH-1:0] skidDataReg;
    logic             mainValid;
    logic             inFire;
    logic             outFire;

    assign inFire  = in_valid & in_ready;
    assign outFire = out_valid & out_ready;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg <= EMPTY;
        end else begin
            stateReg <= stateNext;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. Flush overrides everything, including a same-cycle
    // accept, which is why it is tested before the handshake cases.
    // -------------------------------------------------------------------------
    always_comb begin
        stateNext = stateReg;
        if (flush) begin
            stateNext = EMPTY;
        end else begin
            case (stateReg)
                EMPTY: begin
                    if (inFire) stateNext = ONE;
                end
                ONE: begin
                    case ({inFire, outFire})
                        2'b10:   stateNext = FULL;
                        2'b01:   stateNext = EMPTY;
                        default: stateNext = ONE;
                    endcase
                end
                FULL: begin
                    if (outFire) stateNext = ONE;
                end
                default: stateNext = EMPTY;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output logic. in_ready looks at the registered state (and rst) only.
    // -------------------------------------------------------------------------
    always_comb begin
        mainValid = (stateReg != EMPTY);
        in_ready  = (stateReg != FULL) && !rst;
        out_valid = mainValid;
        out_data  = mainValid ? mainDataReg : NOP_VALUE;
    end

    // -------------------------------------------------------------------------
    // Payload registers. The main entry always holds the oldest word; the
    // skid entry only catches a word that arrives while main is stalled.
    // A flush leaves the payloads untouched; the cleared state masks them.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mainDataReg <= NOP_VALUE;
            skidDataReg <= NOP_VALUE;
        end else if (!flush) begin
            case (stateReg)
                EMPTY: begin
                    if (inFire) mainDataReg <= in_data;
                end
                ONE: begin
                    if (inFire && outFire) begin
                        mainDataReg <= in_data;
                    end else if (inFire) begin
                        skidDataReg <= in_data;
                    end
                end
                FULL: begin
                    if (outFire) mainDataReg <= skidDataReg;
                end
                default: ;
            endcase
        end
    end

`ifdef PIPE_SKID_STATS_EN
    // -------------------------------------------------------------------------
    // Statistics counters: saturate at all-ones, survive flush.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= 8'd0;
        end else if (flush && (stateReg != EMPTY) && (flush_cnt != 8'hFF)) begin
            flush_cnt <= flush_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// Testbench for pipe_skid_stage.
// A queue of at most two words models the stage; a compare process checks
// the 32-bit instance against it on every falling edge. Directed sequences
// add literal expectations, and a second instance (WIDTH=9, NOP=0x1FF)
// covers the parametrised bubble value.
// -----------------------------------------------------------------------------
module tb_pipe_skid_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid  = 1'b0;
    logic [31:0] in_data   = 32'd0;
    logic        out_ready = 1'b0;
    logic        flush     = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;

    logic        inValid9  = 1'b0;
    logic [8:0]  inData9   = 9'd0;
    logic        outReady9 = 1'b1;
    logic        flush9    = 1'b0;
    logic        inReady9;
    logic        outValid9;
    logic [8:0]  outData9;

`ifdef PIPE_SKID_STATS_EN
    logic [15:0] stallCnt;
    logic [7:0]  flushCnt;
    logic [15:0] stallCnt9;
    logic [7:0]  flushCnt9;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush)
`ifdef PIPE_SKID_STATS_EN
        ,
        .stall_cnt (stallCnt),
        .flush_cnt (flushCnt)
`endif
    );

    pipe_skid_stage #(.WIDTH(9), .NOP_VALUE(9'h1FF)) dut9 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid9),
        .in_ready  (inReady9),
        .in_data   (inData9),
        .out_valid (outValid9),
        .out_ready (outReady9),
        .out_data  (outData9),
        .flush     (flush9)
`ifdef PIPE_SKID_STATS_EN
        ,
        .stall_cnt (stallCnt9),
        .flush_cnt (flushCnt9)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: FIFO of capacity two, words leave in arrival order.
    // -------------------------------------------------------------------------
    logic [31:0] q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else begin
            automatic bit canTake = (q.size() < 2);
            automatic bit takeIn  = in_valid && canTake;
            automatic bit giveOut = (q.size() > 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (giveOut) void'(q.pop_front());
                if (takeIn)  q.push_back(in_data);
            end
        end
    end

    always @(negedge clk) begin
        chk("model_out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk("model_out_data", out_data, (q.size() > 0) ? q[0] : 32'd0);
        chk("model_in_ready", {31'd0, in_ready}, {31'd0, !rst && (q.size() < 2)});
    end

    // Apply inputs just after a falling edge, then wait for the next one.
    task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_data9", {23'd0, outData9}, 32'h1FF);
        rst = 1'b0;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);

        // Parametrised instance: bubble is 0x1FF, one word passes through
        inValid9 = 1'b1;
        inData9  = 9'h005;
        @(negedge clk);
        inValid9 = 1'b0;
        chk("p9_out_valid", {31'd0, outValid9}, 32'd1);
        chk("p9_out_data", {23'd0, outData9}, 32'h005);
        @(negedge clk);
        chk("p9_back_to_nop", {23'd0, outData9}, 32'h1FF);
        chk("p9_valid_clear", {31'd0, outValid9}, 32'd0);

        // Streaming, no gaps
        drive(1'b1, 32'h1, 1'b1, 1'b0);
        chk("stream_1", out_data, 32'h1);
        drive(1'b1, 32'h2, 1'b1, 1'b0);
        chk("stream_2", out_data, 32'h2);
        chk("stream_rdy", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 32'h3, 1'b1, 1'b0);
        chk("stream_3", out_data, 32'h3);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stream_drain", {31'd0, out_valid}, 32'd0);

        // Stall fills the skid, then drains in order
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        chk("stall_A", out_data, 32'hA);
        chk("stall_rdy1", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        chk("full_rdy", {31'd0, in_ready}, 32'd0);
        chk("full_hold_A", out_data, 32'hA);
        drive(1'b1, 32'hEE, 1'b0, 1'b0);
        chk("full_hold_A2", out_data, 32'hA);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain_B", out_data, 32'hB);
        chk("drain_rdy", {31'd0, in_ready}, 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain_empty", {31'd0, out_valid}, 32'd0);

        // Flush while FULL with an offered word
        drive(1'b1, 32'h21, 1'b0, 1'b0);
        drive(1'b1, 32'h22, 1'b0, 1'b0);
        drive(1'b1, 32'hC, 1'b0, 1'b1);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_data", out_data, 32'd0);
        chk("flush_rdy", {31'd0, in_ready}, 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("flush_no_C", {31'd0, out_valid}, 32'd0);

        // Flush in ONE with a same-cycle accept discards the new word
        drive(1'b1, 32'h31, 1'b0, 1'b0);
        drive(1'b1, 32'h32, 1'b0, 1'b1);
        chk("flush_one_valid", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-stream
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        chk("pre_rst_data", out_data, 32'h11);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_data", out_data, 32'd0);
        chk("arst_rdy", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_release_rdy", {31'd0, in_ready}, 32'd1);

        // Random traffic checked against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

`ifdef PIPE_SKID_STATS_EN
        // Saturating stall counter and flush counter
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 32'h77, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (70000) @(negedge clk);
        chk("stall_cnt_sat", {16'd0, stallCnt}, 32'hFFFF);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b1, 32'h5, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b1, 32'h6, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        chk("flush_cnt_3", {24'd0, flushCnt}, 32'd3);
        chk("stall_cnt_hold", {16'd0, stallCnt}, 32'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
